// File: rtl/ibus_axi_rd_bridge.sv
// Purpose: responder for the fetch-stage ibus; each request becomes one AXI4 INCR read burst of 1 or 2 beats.
// Latency: AR valid the cycle after accept; data_ok the cycle after the completing R beat is accepted.
// Backpressure: addr_ok withheld while AR is pending or OUTSTANDING requests are in flight; rready drops while a finished response waits.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   ibus_req/addr -> addr_ok     fetch request and same-cycle accept
//   ibus_data_ok/data/index/err  one-cycle response pulse, in request order
//   ar*                          AXI read address channel (arid/arsize/arburst constant)
//   r*                           AXI read data channel
module ibus_axi_rd_bridge #(
  parameter int unsigned OUTSTANDING = 2,
  parameter logic [3:0]  AXI_ID      = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ibus_req,
  input  logic [31:0] ibus_addr,
  output logic        ibus_addr_ok,
  output logic        ibus_data_ok,
  output logic [63:0] ibus_data,
  output logic        ibus_index,
  output logic        ibus_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned   PW       = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);

  // In-flight bookkeeping; FIFO occupancy always equals count.
  logic [2:0]             count;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [OUTSTANDING-1:0] idx_mem;

  // Beat assembly for the head entry.
  logic        beat_cnt;
  logic        err_q;
  logic [31:0] lo_q;

  logic        accept;
  logic        beat_fire;
  logic        head_idx;
  logic        rresp_bad;
  logic        complete;
  logic [63:0] cmpl_data;
  logic        cmpl_err;
  logic        unused_addr_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign arid    = AXI_ID;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  assign unused_addr_bits = ^ibus_addr[1:0];

  // arvalid is the registered copy, so an AR handshake this cycle still refuses a new request.
  assign accept       = ibus_req & ~arvalid & (count < 3'(OUTSTANDING));
  assign ibus_addr_ok = accept;

  // A completed head waits one cycle for data_ok; no beat may be taken for it meanwhile.
  assign rready    = (count != 3'd0) & ~ibus_data_ok;
  assign beat_fire = rvalid & rready;
  assign head_idx  = idx_mem[rd_ptr];
  assign rresp_bad = (rresp != 2'b00);

  always_comb begin
    complete  = 1'b0;
    cmpl_data = {32'h0, rdata};
    cmpl_err  = err_q | rresp_bad;
    if (beat_fire) begin
      if (head_idx) begin
        // single-instruction fetch: first beat always finishes it, rlast must be set
        complete = 1'b1;
        cmpl_err = err_q | rresp_bad | ~rlast;
      end else if (!beat_cnt) begin
        // early rlast truncates a pair fetch: finish now with the high word zeroed
        if (rlast) begin
          complete = 1'b1;
          cmpl_err = 1'b1;
        end
      end else begin
        complete  = 1'b1;
        cmpl_data = {rdata, lo_q};
        cmpl_err  = err_q | rresp_bad | ~rlast;
      end
    end
  end

  // AR channel: payload held stable until the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arvalid <= 1'b0;
      araddr  <= 32'h0;
      arlen   <= 8'h0;
    end else if (accept) begin
      arvalid <= 1'b1;
      araddr  <= ibus_addr[2] ? {ibus_addr[31:2], 2'b00} : {ibus_addr[31:3], 3'b000};
      arlen   <= {7'd0, ~ibus_addr[2]};
    end else if (arready) begin
      arvalid <= 1'b0;
    end
  end

  // Pending FIFO of index bits plus in-flight count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= 3'd0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      idx_mem <= '0;
    end else begin
      if (accept) begin
        idx_mem[wr_ptr] <= ibus_addr[2];
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (ibus_data_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({accept, ibus_data_ok})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Beat collection; counter and sticky error clear when the response leaves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt <= 1'b0;
      err_q    <= 1'b0;
      lo_q     <= 32'h0;
    end else if (ibus_data_ok) begin
      beat_cnt <= 1'b0;
      err_q    <= 1'b0;
    end else if (beat_fire && !complete) begin
      beat_cnt <= 1'b1;
      lo_q     <= rdata;
      err_q    <= err_q | rresp_bad;
    end
  end

  // Response registers: loaded on the completing beat, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ibus_data_ok <= 1'b0;
      ibus_data    <= 64'h0;
      ibus_index   <= 1'b0;
      ibus_err     <= 1'b0;
    end else begin
      ibus_data_ok <= complete;
      if (complete) begin
        ibus_data  <= cmpl_data;
        ibus_index <= head_idx;
        ibus_err   <= cmpl_err;
      end
    end
  end

endmodule

// File: tb/tb_ibus_axi_rd_bridge.sv
// Testbench for ibus_axi_rd_bridge: directed scenarios with literal expectations,
// then randomized fetch/AXI traffic compared every cycle against a queue-based model.
// Ports: drives every DUT input, observes every DUT output.
module tb_ibus_axi_rd_bridge;

  localparam int OUTS = 2;

  logic        clk;
  logic        reset;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_addr_ok;
  logic        ibus_data_ok;
  logic [63:0] ibus_data;
  logic        ibus_index;
  logic        ibus_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  ibus_axi_rd_bridge #(.OUTSTANDING(OUTS), .AXI_ID(4'd0)) dut (
    .clk(clk), .reset(reset),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_addr_ok(ibus_addr_ok),
    .ibus_data_ok(ibus_data_ok), .ibus_data(ibus_data), .ibus_index(ibus_index), .ibus_err(ibus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_pass;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: each accepted request waits in pend_q until its data_ok.
  typedef struct {
    logic        idx;
    int          nb;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
  } ent_t;

  ent_t        pend_q[$];
  logic        m_ar_busy;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_dok;
  logic [63:0] m_data;
  logic        m_idx;
  logic        m_err;

  // AXI slave state for the random phase: lengths of granted bursts.
  int slv_q[$];
  int slv_beat;

  // Observations from the latest sample.
  logic        acc_seen, ar_hs_seen, r_hs_seen, dok_seen;
  logic [63:0] last_data;
  logic        last_idx, last_err;
  int          cyc, last_acc_cyc, last_dok_cyc, last_r_cyc;

  task automatic model_reset();
    pend_q.delete();
    m_ar_busy = 1'b0;
    m_dok     = 1'b0;
  endtask

  task automatic compare_cycle();
    logic e_acc;
    logic e_rdy;
    ent_t e;
    cyc++;
    acc_seen   = ibus_addr_ok;
    ar_hs_seen = arvalid & arready;
    r_hs_seen  = rvalid & rready;
    dok_seen   = ibus_data_ok;
    if (ibus_addr_ok) last_acc_cyc = cyc;
    if (r_hs_seen) last_r_cyc = cyc;
    if (ibus_data_ok) begin
      last_dok_cyc = cyc;
      last_data    = ibus_data;
      last_idx     = ibus_index;
      last_err     = ibus_err;
    end
    if (ar_hs_seen) slv_q.push_back(int'(arlen));
    if (reset) return;

    e_acc = ibus_req && !m_ar_busy && (pend_q.size() < OUTS);
    e_rdy = (pend_q.size() > 0) && !m_dok;
    chk("addr_ok", ibus_addr_ok, e_acc);
    chk("arvalid", arvalid, m_ar_busy);
    chk("rready", rready, e_rdy);
    chk("data_ok", ibus_data_ok, m_dok);
    if (m_ar_busy) begin
      chk("araddr", araddr, m_araddr);
      chk("arlen", arlen, m_arlen);
    end
    if (m_dok) begin
      chk("data", ibus_data, m_data);
      chk("index", ibus_index, m_idx);
      chk("err", ibus_err, m_err);
    end

    // Advance the model across the coming edge.
    if (m_dok) begin
      void'(pend_q.pop_front());
      m_dok = 1'b0;
    end
    if (m_ar_busy && arready) m_ar_busy = 1'b0;
    if (e_acc) begin
      e.idx = ibus_addr[2];
      e.nb  = 0;
      e.lo  = 32'h0;
      e.hi  = 32'h0;
      e.err = 1'b0;
      pend_q.push_back(e);
      m_ar_busy = 1'b1;
      m_araddr  = ibus_addr & (e.idx ? 32'hFFFF_FFFC : 32'hFFFF_FFF8);
      m_arlen   = e.idx ? 8'd0 : 8'd1;
    end
    if (rvalid && e_rdy) begin
      e = pend_q[0];
      e.nb++;
      if (rresp != 2'b00) e.err = 1'b1;
      if (e.nb == 1) e.lo = rdata;
      else e.hi = rdata;
      if (e.idx || e.nb == 2 || rlast) begin
        // rlast must mark exactly the expected final beat
        if (e.idx ? !rlast : (e.nb == 1 || !rlast)) e.err = 1'b1;
        m_dok  = 1'b1;
        m_idx  = e.idx;
        m_err  = e.err;
        m_data = {((e.nb == 2) ? e.hi : 32'h0), e.lo};
      end
      pend_q[0] = e;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input logic [31:0] a);
    ibus_req  = 1'b1;
    ibus_addr = a;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc_seen) break;
    end
    chk("req_accept_timeout", acc_seen, 1'b1);
    ibus_req = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
    rvalid = 1'b1;
    rdata  = d;
    rresp  = resp;
    rlast  = last;
    for (int i = 0; i < 20; i++) begin
      step();
      if (r_hs_seen) break;
    end
    chk("beat_timeout", r_hs_seen, 1'b1);
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  task automatic wait_dok();
    for (int i = 0; i < 20; i++) begin
      step();
      if (dok_seen) break;
    end
    chk("data_ok_timeout", dok_seen, 1'b1);
  endtask

  task automatic rand_drive(input bit fetch_en);
    if (r_hs_seen) begin
      if (slv_q.size() > 0) begin
        if (rlast || slv_beat >= slv_q[0]) begin
          void'(slv_q.pop_front());
          slv_beat = 0;
        end else begin
          slv_beat++;
        end
      end
      rvalid = 1'b0;
    end
    if (!rvalid && slv_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      rvalid = 1'b1;
      rdata  = $urandom();
      rresp  = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      if (slv_q[0] == 0) rlast = ($urandom_range(0, 7) != 0);
      else if (slv_beat == 0) rlast = ($urandom_range(0, 7) == 0);
      else rlast = 1'b1;
    end
    arready = ($urandom_range(0, 2) != 0);
    if (acc_seen || !ibus_req) ibus_addr = $urandom();
    ibus_req = fetch_en && ($urandom_range(0, 2) != 0);
  endtask

  initial begin
    int acc;
    logic [7:0] mask;
    n_checks = 0; n_pass = 0;
    cyc = 0; last_acc_cyc = 0; last_dok_cyc = 0; last_r_cyc = 0;
    last_data = 64'h0; last_idx = 1'b0; last_err = 1'b0;
    slv_beat = 0;
    model_reset();
    reset = 1'b1; ibus_req = 1'b0; ibus_addr = 32'h0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0;

    // Reset state
    #1;
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_addr_ok", ibus_addr_ok, 1'b0);
    chk("rst_data_ok", ibus_data_ok, 1'b0);
    chk("rst_err", ibus_err, 1'b0);
    chk("rst_data", ibus_data, 64'h0);
    chk("rst_index", ibus_index, 1'b0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_arlen", arlen, 8'h0);
    chk("rst_constants", {arid, arsize, arburst}, {4'd0, 3'b010, 2'b01});
    repeat (2) step();
    reset = 1'b0;

    // Single aligned fetch
    arready = 1'b1;
    issue_req(32'hBFC0_0000);
    chk("t1_araddr", araddr, 32'hBFC0_0000);
    chk("t1_arlen", arlen, 8'd1);
    send_beat(32'h1111_1111, 2'b00, 1'b0);
    send_beat(32'h2222_2222, 2'b00, 1'b1);
    wait_dok();
    chk("t1_data", last_data, 64'h2222_2222_1111_1111);
    chk("t1_index", last_idx, 1'b0);
    chk("t1_err", last_err, 1'b0);
    chk("t1_dok_latency", 64'(last_dok_cyc - last_r_cyc), 64'd1);

    // Unaligned fetch
    issue_req(32'hBFC0_0004);
    chk("t2_araddr", araddr, 32'hBFC0_0004);
    chk("t2_arlen", arlen, 8'd0);
    send_beat(32'hAAAA_5555, 2'b00, 1'b1);
    wait_dok();
    chk("t2_data", last_data, 64'h0000_0000_AAAA_5555);
    chk("t2_index", last_idx, 1'b1);

    // AR backpressure
    arready = 1'b0;
    issue_req(32'h0000_4000);
    ibus_req  = 1'b1;
    ibus_addr = 32'h0000_5004;
    acc = 0;
    repeat (5) begin
      step();
      if (acc_seen) acc++;
      chk("bp_araddr", araddr, 32'h0000_4000);
      chk("bp_arvalid", arvalid, 1'b1);
    end
    chk("bp_no_accept", acc, 0);
    arready = 1'b1;
    step();
    chk("bp_handshake", ar_hs_seen, 1'b1);
    step();
    chk("bp_reopen", acc_seen, 1'b1);
    ibus_req = 1'b0;
    send_beat(32'hCAFE_0000, 2'b00, 1'b0);
    send_beat(32'hCAFE_0001, 2'b00, 1'b1);
    wait_dok();
    chk("bp_data0", last_data, 64'hCAFE_0001_CAFE_0000);
    send_beat(32'hBEEF_0002, 2'b00, 1'b1);
    wait_dok();
    chk("bp_data1", last_data, 64'h0000_0000_BEEF_0002);
    chk("bp_index1", last_idx, 1'b1);

    // Errors
    issue_req(32'h0000_2000);
    send_beat(32'hDEAD_0001, 2'b10, 1'b0);
    send_beat(32'hDEAD_0002, 2'b00, 1'b1);
    wait_dok();
    chk("e1_err", last_err, 1'b1);
    chk("e1_data", last_data, 64'hDEAD_0002_DEAD_0001);
    issue_req(32'h0000_3000);
    send_beat(32'h1234_5678, 2'b00, 1'b1);
    wait_dok();
    chk("e2_err", last_err, 1'b1);
    chk("e2_data", last_data, 64'h0000_0000_1234_5678);
    chk("e2_index", last_idx, 1'b0);

    // Outstanding limit
    ibus_req  = 1'b1;
    ibus_addr = 32'h0000_1000;
    mask = 8'h0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (acc_seen) mask[i] = 1'b1;
    end
    chk("os_accept_pattern", mask, 8'b0000_0101);
    send_beat(32'h5555_0000, 2'b00, 1'b0);
    send_beat(32'h5555_0001, 2'b00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      if (acc_seen) break;
    end
    ibus_req = 1'b0;
    chk("os_reopen_delay", 64'(last_acc_cyc - last_dok_cyc), 64'd1);

    // Reset with two requests in flight
    reset = 1'b1;
    #1;
    chk("mr_arvalid", arvalid, 1'b0);
    chk("mr_rready", rready, 1'b0);
    chk("mr_data_ok", ibus_data_ok, 1'b0);
    chk("mr_data", ibus_data, 64'h0);
    chk("mr_araddr", araddr, 32'h0);
    chk("mr_arlen", arlen, 8'h0);
    model_reset();
    repeat (2) step();
    reset = 1'b0;
    ibus_req  = 1'b1;
    ibus_addr = 32'hBFC0_0000;
    step();
    chk("mr_first_accept", acc_seen, 1'b1);
    ibus_req = 1'b0;
    issue_req(32'hBFC0_0008);
    send_beat(32'h0000_0001, 2'b00, 1'b0);
    send_beat(32'h0000_0002, 2'b00, 1'b1);
    wait_dok();
    send_beat(32'h0000_0003, 2'b00, 1'b0);
    send_beat(32'h0000_0004, 2'b00, 1'b1);
    wait_dok();
    chk("mr_last_data", last_data, 64'h0000_0004_0000_0003);

    // Randomized traffic
    slv_q.delete();
    slv_beat = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      rand_drive(1'b1);
    end
    for (int i = 0; i < 500; i++) begin
      step();
      rand_drive(1'b0);
      if (pend_q.size() == 0 && !m_dok && !m_ar_busy) break;
    end
    chk("drain_empty", pend_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ibus_axi_rd_bridge.md
Name: ibus_axi_rd_bridge

Overview:
- Responder end of the instruction-bus handshake driven by the fetch stage (req/addr out; addr_ok/data_ok/data/index back).
- Accepts fetch requests and converts each into one AXI4 read burst of one or two 32-bit beats.
- Packs the beats into the 64-bit ibus data word and returns responses strictly in request order, with a bounded number in flight.
- Sits between the fetch stage and the AXI read channels of the instruction-side interconnect.

Parameters:
- OUTSTANDING, 2, max requests accepted but not yet answered with data_ok (1..4).
- AXI_ID, 4'd0, constant arid value.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ibus_req  input  1  fetch request valid.
- ibus_addr  input  32  fetch address, word aligned; addr[1:0] ignored.
- ibus_addr_ok  output  1  request accepted this cycle.
- ibus_data_ok  output  1  one-cycle pulse, response valid.
- ibus_data  output  64  instruction pair; valid only while data_ok=1.
- ibus_index  output  1  1 = single instruction in data[31:0].
- ibus_err  output  1  qualified by data_ok; AXI error or rlast mismatch.
- arid  output  4  =AXI_ID.
- araddr  output  32  burst start address.
- arlen  output  8  0 or 1.
- arsize  output  3  constant 3'b010.
- arburst  output  2  constant INCR (2'b01).
- arvalid  output  1  AR valid.
- arready  input  1  AR ready.
- rdata  input  32  read beat data.
- rresp  input  2  read response.
- rlast  input  1  last beat.
- rvalid  input  1  R valid.
- rready  output  1  R ready.

Behaviour:
- Reset: arvalid=0, rready=0, ibus_addr_ok=0, ibus_data_ok=0, ibus_err=0, ibus_data=0, ibus_index=0, araddr=0, arlen=0. In-flight count=0, FIFO empty, beat counter=0.
- Reset mid-operation discards all in-flight state; the interconnect is reset by the same signal.
- Accept (combinational): ibus_addr_ok = ibus_req & ~arvalid & (count < OUTSTANDING). There is no combinational path from arready or any R signal.
- On accept, AR registers load on the next edge:
  - addr[2]=0: araddr={addr[31:3],3'b000}, arlen=1.
  - addr[2]=1: araddr={addr[31:2],2'b00}, arlen=0.
  - arvalid<=1 and is held, with stable payload, until the cycle arvalid&arready.
- Minimum accept spacing is 2 cycles: arvalid blocks the following cycle.
- Pending FIFO (depth OUTSTANDING) pushes the index bit (addr[2]) on accept and pops on data_ok.
- count increments on accept and decrements on data_ok; both in one cycle leaves it unchanged. count never exceeds OUTSTANDING.
- rready=1 iff count>0 and the FIFO head is not already completed-and-waiting. R beats while count=0 are not accepted.
- Beat assembly for head entry, beat counter b:
  - Head index=0: beat b=0 -> low word; beat b=1 -> high word, completes. rlast on b=0 completes early with err=1 and high word=0.
  - Head index=1: beat 0 -> low word, completes; high word=0. rlast=0 on this beat sets err, but the entry still completes on that beat.
  - Any beat with rresp!=2'b00 sets the sticky entry error bit.
- Completion: the cycle after the completing beat is accepted, ibus_data_ok=1 for exactly one cycle with ibus_data/ibus_index/ibus_err. The beat counter and error bit clear at the same time.
- Responses are returned in request order. Back-to-back bursts give data_ok pulses on consecutive completions.
- ibus_data/ibus_index/ibus_err are held at the last values when data_ok=0; the fetch stage does not sample them then.
- AR accepted in the same cycle as a new ibus_req: the new request is still refused that cycle, because addr_ok uses the registered arvalid.

Test Plan:
- Single aligned fetch: req addr 0xBFC00000, arready=1, R beats 0x11111111 then 0x22222222 (rlast) -> araddr 0xBFC00000, arlen=1; data_ok one cycle after beat 2; data=0x2222222211111111, index=0, err=0.
- Unaligned fetch: addr 0xBFC00004, one R beat 0xAAAA5555 with rlast -> araddr 0xBFC00004, arlen=0; data=0x00000000AAAA5555, index=1.
- Outstanding limit: OUTSTANDING=2, req held high, arready=1, no R beats -> exactly 2 addr_ok pulses (cycles 0 and 2), then addr_ok=0. One completion reopens acceptance the cycle after data_ok.
- AR backpressure: arready low for 5 cycles -> arvalid and araddr stable, addr_ok=0 for the whole wait; handshake on cycle 6.
- Errors: 2-beat request with rresp=2'b10 on beat 0 -> err=1 with data_ok. 2-beat request with rlast on beat 0 -> completes after one beat, err=1, data[63:32]=0.
- Reset asserted with 2 requests in flight -> all outputs 0 immediately (asynchronous). After release, a new request is accepted first cycle with count restarting from 0.
